// File: rtl/arm_cortex_m0_shifter_pkg.sv
// Shared encodings for the Cortex-M0 iterative shifter: shift types, FSM states
// and the iteration caps that produce the ARMv6-M results for large amounts.
package arm_cortex_m0_pkg;

    typedef logic [1:0] shift_type_t;

    localparam shift_type_t SH_LSL = 2'b00;
    localparam shift_type_t SH_LSR = 2'b01;
    localparam shift_type_t SH_ASR = 2'b10;
    localparam shift_type_t SH_ROR = 2'b11;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // One step past 32 pushes the last data bit out of the carry for LSL/LSR.
    localparam logic [7:0] LSL_LSR_CAP = 8'd33;
    localparam logic [7:0] ASR_CAP     = 8'd32;

    localparam int CNT_W = 6;

endpackage

// File: rtl/arm_cortex_m0_shifter_if.sv
// Request/response bundle between the operand fetch stage (master) and the
// shifter (slave).
interface arm_cortex_m0_shifter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int AMT_WIDTH  = 8
);
    logic                  start;
    logic [1:0]            shift_type;
    logic [DATA_WIDTH-1:0] value;
    logic [AMT_WIDTH-1:0]  amount;
    logic                  carry_in;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;
    logic                  carry_out;

    modport master (
        output start, shift_type, value, amount, carry_in,
        input  busy, done, result, carry_out
    );

    modport slave (
        input  start, shift_type, value, amount, carry_in,
        output busy, done, result, carry_out
    );
endinterface

// File: rtl/arm_cortex_m0_shift_step.sv
// Combinational single-bit shift step; c_o is the bit that leaves the word.
module arm_cortex_m0_shift_step
    import arm_cortex_m0_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] r_i,
    input  shift_type_t           type_i,
    output logic [DATA_WIDTH-1:0] r_o,
    output logic                  c_o
);

    always_comb begin
        r_o = r_i;
        c_o = 1'b0;
        case (type_i)
            SH_LSL: begin
                c_o = r_i[DATA_WIDTH-1];
                r_o = {r_i[DATA_WIDTH-2:0], 1'b0};
            end
            SH_LSR: begin
                c_o = r_i[0];
                r_o = {1'b0, r_i[DATA_WIDTH-1:1]};
            end
            SH_ASR: begin
                c_o = r_i[0];
                r_o = {r_i[DATA_WIDTH-1], r_i[DATA_WIDTH-1:1]};
            end
            SH_ROR: begin
                c_o = r_i[0];
                r_o = {r_i[0], r_i[DATA_WIDTH-1:1]};
            end
            default: begin
                r_o = r_i;
                c_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/arm_cortex_m0_shifter.sv
// Iterative LSL/LSR/ASR/ROR unit feeding ALU operand_B and the C flag; one bit
// per cycle under a start/busy/done handshake.
module arm_cortex_m0_shifter
    import arm_cortex_m0_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int AMT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    arm_cortex_m0_shifter_if.slave  sh
);

    logic [0:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] r_q, r_d;
    logic                  c_q, c_d;
    shift_type_t           type_q, type_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  carry_q, carry_d;
    logic                  done_q, done_d;

    logic [CNT_W-1:0]      n_calc;
    logic                  ror_wrap;
    logic [DATA_WIDTH-1:0] step_r;
    logic                  step_c;

    arm_cortex_m0_shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .r_i    (r_q),
        .type_i (type_q),
        .r_o    (step_r),
        .c_o    (step_c)
    );

    // Capped step counts reproduce the architectural results for amounts >= 32.
    always_comb begin
        n_calc = '0;
        case (sh.shift_type)
            SH_LSL, SH_LSR: n_calc = (sh.amount > LSL_LSR_CAP) ? LSL_LSR_CAP[CNT_W-1:0]
                                                               : sh.amount[CNT_W-1:0];
            SH_ASR:         n_calc = (sh.amount > ASR_CAP) ? ASR_CAP[CNT_W-1:0]
                                                           : sh.amount[CNT_W-1:0];
            default:        n_calc = {1'b0, sh.amount[4:0]};
        endcase
    end

    // ROR by a non-zero multiple of 32 takes no steps but still reports bit 31.
    assign ror_wrap = (sh.shift_type == SH_ROR) && (sh.amount != '0) && (sh.amount[4:0] == 5'd0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        c_d      = c_q;
        type_d   = type_q;
        result_d = result_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sh.start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = n_calc;
                    r_d     = sh.value;
                    type_d  = sh.shift_type;
                    c_d     = ror_wrap ? sh.value[DATA_WIDTH-1] : sh.carry_in;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    r_d   = step_r;
                    c_d   = step_c;
                end else begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    result_d = r_q;
                    carry_d  = c_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            r_q      <= '0;
            c_q      <= 1'b0;
            type_q   <= SH_LSL;
            result_q <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            c_q      <= c_d;
            type_q   <= type_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
        end
    end

    assign sh.busy      = (state_q == ST_SHIFT);
    assign sh.done      = done_q;
    assign sh.result    = result_q;
    assign sh.carry_out = carry_q;

endmodule
